// File: rtl/shift_seq_unit.sv
// X:A:B shift chain with whole/partial loads, single-step shifts and a self-timed multi-step sequencer.
// Define SHIFT_SEQ_ROTATE_EN to build rotate-right for Mode 10; otherwise Mode 10 is a logical right shift.
module shift_seq_unit #(
    parameter int W     = 8,
    parameter int CNT_W = $clog2(2*W+2)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic             Load_A,
    input  logic             X_In,
    input  logic [W-1:0]     D_A,
    input  logic [W-1:0]     D_B,
    input  logic             Shift_En,
    input  logic             Start,
    input  logic [CNT_W-1:0] Count,
    input  logic [1:0]       Mode,
    output logic             X,
    output logic [2*W-1:0]   Data_Out,
    output logic             Shift_Out,
    output logic             Busy,
    output logic             Done
);

    localparam int CHAIN_W = 2*W+1;
    localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(CHAIN_W);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_next;
    logic [CHAIN_W-1:0] chain, chain_next;
    logic [CNT_W-1:0]   cnt_q, cnt_next, count_sat;
    logic [1:0]         mode_q, mode_next;
    logic               done_next;

    // One step of the whole chain; MSB is X, LSB is B[0].
    function automatic logic [CHAIN_W-1:0] shift_chain(input logic [CHAIN_W-1:0] c,
                                                       input logic [1:0] m);
        logic [CHAIN_W-1:0] r;
        case (m)
            2'b00:   r = {c[CHAIN_W-1], c[CHAIN_W-1:1]};
            2'b01:   r = {1'b0, c[CHAIN_W-1:1]};
`ifdef SHIFT_SEQ_ROTATE_EN
            2'b10:   r = {c[0], c[CHAIN_W-1:1]};
`else
            2'b10:   r = {1'b0, c[CHAIN_W-1:1]};
`endif
            default: r = {c[CHAIN_W-2:0], 1'b0};
        endcase
        return r;
    endfunction

    always_comb begin
        count_sat = (Count > MAX_COUNT) ? MAX_COUNT : Count;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Requests are honoured only in IDLE, highest priority first; RUN ignores them all.
    always_comb begin
        state_next = state;
        chain_next = chain;
        cnt_next   = cnt_q;
        mode_next  = mode_q;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (Load) begin
                    chain_next = {X_In, D_A, D_B};
                end else if (Load_A) begin
                    chain_next = {X_In, D_A, chain[W-1:0]};
                end else if (Start) begin
                    if (count_sat == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = RUN;
                        cnt_next   = count_sat;
                        mode_next  = Mode;
                    end
                end else if (Shift_En) begin
                    chain_next = shift_chain(chain, Mode);
                end
            end
            RUN: begin
                chain_next = shift_chain(chain, mode_q);
                cnt_next   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            chain  <= '0;
            cnt_q  <= '0;
            mode_q <= '0;
            Done   <= 1'b0;
        end else begin
            chain  <= chain_next;
            cnt_q  <= cnt_next;
            mode_q <= mode_next;
            Done   <= done_next;
        end
    end

    assign X         = chain[CHAIN_W-1];
    assign Data_Out  = chain[2*W-1:0];
    assign Shift_Out = chain[0];
    assign Busy      = (state == RUN);

endmodule

// File: tb/tb_shift_seq_unit.sv
// Directed plus randomized bench for shift_seq_unit against an integer-arithmetic model of the chain.
module tb_shift_seq_unit;

    localparam int W     = 8;
    localparam int CNT_W = 5;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Load, Load_A, X_In, Shift_En, Start;
    logic [W-1:0]     D_A, D_B;
    logic [CNT_W-1:0] Count;
    logic [1:0]       Mode;
    logic             X, Shift_Out, Busy, Done;
    logic [2*W-1:0]   Data_Out;

    int          total = 0;
    int          bad   = 0;
    logic [16:0] m_chain;

    shift_seq_unit #(.W(W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Load(Load), .Load_A(Load_A), .X_In(X_In),
        .D_A(D_A), .D_B(D_B), .Shift_En(Shift_En), .Start(Start), .Count(Count),
        .Mode(Mode), .X(X), .Data_Out(Data_Out), .Shift_Out(Shift_Out),
        .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    // Chain treated as a 17-bit integer: bit 16 is X, bit 0 is B[0].
    function automatic logic [16:0] modelStep(input logic [16:0] c, input logic [1:0] md);
        int unsigned v;
        int unsigned r;
        v = 32'(c);
        case (md)
            2'd0: r = (v >> 1) | (v & 32'h1_0000);
            2'd1: r = v >> 1;
`ifdef SHIFT_SEQ_ROTATE_EN
            2'd2: r = (v >> 1) | ((v & 32'h1) << 16);
`else
            2'd2: r = v >> 1;
`endif
            default: r = (v << 1) & 32'h1_FFFF;
        endcase
        return r[16:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic expBusy, input logic expDone);
        check({tag, "_chain"}, 32'({X, Data_Out}), 32'(m_chain));
        check({tag, "_sout"}, 32'(Shift_Out), 32'(m_chain[0]));
        check({tag, "_busy"}, 32'(Busy), 32'(expBusy));
        check({tag, "_done"}, 32'(Done), 32'(expDone));
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ld, input logic lda, input logic st, input logic sen,
                                 input logic x, input logic [7:0] a, input logic [7:0] b,
                                 input logic [4:0] cnt, input logic [1:0] md);
        Load = ld; Load_A = lda; Start = st; Shift_En = sen;
        X_In = x; D_A = a; D_B = b; Count = cnt; Mode = md;
        tick();
        Load = 1'b0; Load_A = 1'b0; Start = 1'b0; Shift_En = 1'b0;
    endtask

    task automatic doLoad(input logic x, input logic [7:0] a, input logic [7:0] b);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, x, a, b, 5'd0, 2'd0);
        m_chain = {x, a, b};
        checkOutput("load", 1'b0, 1'b0);
    endtask

    // Leaves the bench in the Done cycle so a following call starts back-to-back.
    task automatic runSeq(input logic [1:0] md, input int cnt, input bit disturb);
        int n;
        n = (cnt > 17) ? 17 : cnt;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 5'(cnt), md);
        Mode  = 2'($urandom);
        Count = 5'($urandom);
        if (n == 0) begin
            checkOutput("zero", 1'b0, 1'b1);
            return;
        end
        for (int i = 0; i < n; i++) begin
            checkOutput("run", 1'b1, 1'b0);
            if (disturb && i == 1) begin
                Load = 1'b1; Load_A = 1'b1; D_A = 8'hFF; X_In = 1'b1;
                Start = 1'b1; Count = 5'd3; Shift_En = 1'b1;
            end
            tick();
            Load = 1'b0; Load_A = 1'b0; Start = 1'b0; Shift_En = 1'b0;
            m_chain = modelStep(m_chain, md);
        end
        checkOutput("end", 1'b0, 1'b1);
    endtask

    task automatic idleCheck(input string tag);
        tick();
        checkOutput(tag, 1'b0, 1'b0);
    endtask

    initial begin
        Reset = 1'b1; Load = 1'b0; Load_A = 1'b0; Start = 1'b0; Shift_En = 1'b0;
        X_In = 1'b0; D_A = '0; D_B = '0; Count = '0; Mode = '0;
        m_chain = '0;
        #3;
        checkOutput("reset", 1'b0, 1'b0);
        tick();
        Reset = 1'b0;
        idleCheck("post_reset");

        // Arithmetic right sequence of three steps
        doLoad(1'b1, 8'h80, 8'h01);
        runSeq(2'd0, 3, 1'b0);
        check("arith_lit", 32'({X, Data_Out}), 32'h1_F000);
        idleCheck("arith_after");

        // Single logical-left step
        doLoad(1'b0, 8'h40, 8'h81);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 5'd0, 2'd3);
        m_chain = modelStep(m_chain, 2'd3);
        checkOutput("left", 1'b0, 1'b0);
        check("left_lit", 32'({X, Data_Out}), 32'h0_8102);

        // Mode 10 for two steps
        doLoad(1'b0, 8'h00, 8'h03);
        runSeq(2'd2, 2, 1'b0);
`ifdef SHIFT_SEQ_ROTATE_EN
        check("rot_lit", 32'({X, Data_Out}), 32'h1_8000);
`else
        check("rot_lit", 32'({X, Data_Out}), 32'h0_0000);
`endif
        idleCheck("rot_after");

        // Requests during RUN are ignored
        doLoad(1'b1, 8'h35, 8'hC6);
        runSeq(2'd1, 4, 1'b1);
        idleCheck("busy_ign_after");

        // Count=0 pulses Done without shifting, then a back-to-back sequence from the Done cycle
        runSeq(2'd0, 0, 1'b0);
        runSeq(2'd3, 2, 1'b0);
        runSeq(2'd0, 5, 1'b0);
        idleCheck("b2b_after");

        // Load beats Start; Load_A beats Start and Shift_En; Start beats Shift_En
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 8'h5A, 5'd5, 2'd1);
        m_chain = {1'b0, 8'hA5, 8'h5A};
        checkOutput("prio_load", 1'b0, 1'b0);
        idleCheck("prio_load_after");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 8'hFF, 5'd3, 2'd1);
        m_chain = {1'b1, 8'h3C, m_chain[7:0]};
        checkOutput("prio_loada", 1'b0, 1'b0);
        check("prio_loada_lit", 32'({X, Data_Out}), 32'h1_3C5A);
        idleCheck("prio_loada_after");

        // Count above chain length saturates to 17 steps
        doLoad(1'b1, 8'h96, 8'h69);
        runSeq(2'd0, 31, 1'b0);
        idleCheck("sat_after");

        // Asynchronous reset in the middle of a long run
        doLoad(1'b1, 8'hF0, 8'h0F);
        runSeq(2'd1, 0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 5'd10, 2'd3);
        checkOutput("rst_run0", 1'b1, 1'b0);
        tick(); m_chain = modelStep(m_chain, 2'd3);
        tick(); m_chain = modelStep(m_chain, 2'd3);
        checkOutput("rst_run2", 1'b1, 1'b0);
        #2 Reset = 1'b1;
        #1;
        m_chain = '0;
        checkOutput("rst_async", 1'b0, 1'b0);
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 12; i++) idleCheck("rst_quiet");

        // Randomized loads, single steps and sequences
        for (int it = 0; it < 40; it++) begin
            logic       rx;
            logic [7:0] ra, rb;
            rx = 1'($urandom); ra = 8'($urandom); rb = 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                doLoad(rx, ra, rb);
            end else begin
                applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, rx, ra, rb, 5'd0, 2'd0);
                m_chain = {rx, ra, m_chain[7:0]};
                checkOutput("rnd_loada", 1'b0, 1'b0);
            end
            if ($urandom_range(0, 2) == 0) begin
                logic [1:0] md;
                md = 2'($urandom);
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 5'($urandom), md);
                m_chain = modelStep(m_chain, md);
                checkOutput("rnd_step", 1'b0, 1'b0);
            end else begin
                runSeq(2'($urandom), int'($urandom_range(0, 31)), bit'($urandom_range(0, 1)));
                idleCheck("rnd_after");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
